spi_frame_decoder: RTL and testbench

//  Sits directly downstream of SPI_Slave. It consumes received bytes (data_out/data_out_valid),

---
 rtl/spi_frame_decoder_pkg.sv | 21 ++
 rtl/spi_frame_decoder_if.sv | 14 +
 rtl/spi_frame_decoder_reg_bank.sv | 48 ++++
 rtl/spi_frame_decoder.sv | 144 ++++++++++++++
 tb/tb_spi_frame_decoder.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/spi_frame_decoder_pkg.sv
// Shared types and constants for the SPI frame decoder.
// Holds the frame FSM encoding, command/address layout and the status byte default.
package spi_frame_pkg;

  localparam int ADDR_W        = 7;
  localparam int CMD_WRITE_BIT = 7;

  localparam logic [7:0] STATUS_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_WRITE,
    ST_READ
  } frame_state_t;

  function automatic logic in_range(input logic [ADDR_W-1:0] addr, input int count);
    return (32'(addr) < count);
  endfunction

endpackage

// File: rtl/spi_frame_decoder_if.sv
// Byte-level link between SPI_Slave and the frame decoder.
// The master modport is the SPI_Slave side; the slave modport is the decoder.
interface spi_frame_decoder_if;

  logic       cs;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic [7:0] tx_byte;
  logic       tx_valid;

  modport master (output cs, rx_byte, rx_valid, input tx_byte, tx_valid);
  modport slave  (input cs, rx_byte, rx_valid, output tx_byte, tx_valid);

endinterface

// File: rtl/spi_frame_decoder_reg_bank.sv
// Bank of REG_COUNT 8-bit registers with one synchronous write port and one
// combinational read port; out-of-range reads return zero, out-of-range writes are dropped.
module spi_reg_bank
  import spi_frame_pkg::*;
#(
  parameter int         REG_COUNT   = 16,
  parameter logic [7:0] RESET_VALUE = 8'h00
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      waddr,
  input  logic [7:0]             wdata,
  input  logic [ADDR_W-1:0]      raddr,
  output logic [7:0]             rdata,
  output logic [REG_COUNT*8-1:0] regs_flat
);

  logic [7:0] mem [REG_COUNT];

  // Address decode by comparison keeps indexing width-independent of REG_COUNT.
  always_ff @(posedge clk) begin
    for (int i = 0; i < REG_COUNT; i++) begin
      if (rst) begin
        mem[i] <= RESET_VALUE;
      end else if (we && waddr == ADDR_W'(i)) begin
        mem[i] <= wdata;
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      if (raddr == ADDR_W'(i)) begin
        rdata = mem[i];
      end
    end
  end

  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      regs_flat[8*i +: 8] = mem[i];
    end
  end

endmodule

// File: rtl/spi_frame_decoder.sv
// Parses chip-select framed command+burst traffic from SPI_Slave and
// reads/writes a small register bank, returning reply bytes for the next shift.
module spi_frame_decoder
  import spi_frame_pkg::*;
#(
  parameter int         REG_COUNT   = 16,
  parameter logic [7:0] STATUS_BYTE = STATUS_BYTE_DEFAULT,
  parameter logic [7:0] RESET_VALUE = 8'h00
) (
  input  logic                   clk,
  input  logic                   rst,
  spi_frame_decoder_if.slave     bus,
  output logic [REG_COUNT*8-1:0] regs_flat,
  output logic                   wr_strobe,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic                   frame_active,
  output logic                   addr_err
);

  frame_state_t      state_q, state_d;
  logic              cs_meta, cs_sync, cs_prev;
  logic              cs_fall, cs_rise;
  logic [ADDR_W-1:0] addr_q, addr_d, raddr;
  logic [7:0]        rdata, tx_byte_q, tx_next;
  logic              tx_valid_q, tx_load, reg_we, err_set;

  // Sync flops reset low so a reset taken while cs is held low does not restart the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_meta <= 1'b0;
      cs_sync <= 1'b0;
      cs_prev <= 1'b0;
    end else begin
      cs_meta <= bus.cs;
      cs_sync <= cs_meta;
      cs_prev <= cs_sync;
    end
  end

  assign cs_fall = cs_prev & ~cs_sync;
  assign cs_rise = ~cs_prev & cs_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (cs_fall) state_d = ST_CMD;
      ST_CMD:   if (bus.rx_valid) state_d = bus.rx_byte[CMD_WRITE_BIT] ? ST_WRITE : ST_READ;
      ST_WRITE: state_d = ST_WRITE;
      ST_READ:  state_d = ST_READ;
    endcase
    if (cs_rise) begin
      state_d = ST_IDLE;
    end
  end

  // The command byte addresses the first reply; later replies read one past the current address.
  assign raddr = (state_q == ST_CMD) ? bus.rx_byte[ADDR_W-1:0] : addr_q + 1'b1;

  always_comb begin
    addr_d  = addr_q;
    tx_load = 1'b0;
    tx_next = tx_byte_q;
    reg_we  = 1'b0;
    err_set = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          tx_load = 1'b1;
          tx_next = STATUS_BYTE;
        end
      end
      ST_CMD: begin
        if (bus.rx_valid) begin
          addr_d = bus.rx_byte[ADDR_W-1:0];
          if (!bus.rx_byte[CMD_WRITE_BIT]) begin
            tx_load = 1'b1;
            tx_next = rdata;
            err_set = !in_range(raddr, REG_COUNT);
          end
        end
      end
      ST_WRITE: begin
        if (bus.rx_valid) begin
          addr_d  = addr_q + 1'b1;
          reg_we  = in_range(addr_q, REG_COUNT);
          err_set = !in_range(addr_q, REG_COUNT);
        end
      end
      ST_READ: begin
        if (bus.rx_valid) begin
          addr_d  = addr_q + 1'b1;
          tx_load = 1'b1;
          tx_next = rdata;
          err_set = !in_range(raddr, REG_COUNT);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      tx_byte_q  <= '0;
      tx_valid_q <= 1'b0;
      wr_strobe  <= 1'b0;
      wr_addr    <= '0;
      addr_err   <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      tx_valid_q <= tx_load;
      wr_strobe  <= reg_we;
      if (tx_load) tx_byte_q <= tx_next;
      if (reg_we)  wr_addr   <= addr_q;
      if (err_set) addr_err  <= 1'b1;
    end
  end

  assign bus.tx_byte   = tx_byte_q;
  assign bus.tx_valid  = tx_valid_q;
  assign frame_active  = (state_q != ST_IDLE);

  spi_reg_bank #(
    .REG_COUNT   (REG_COUNT),
    .RESET_VALUE (RESET_VALUE)
  ) u_reg_bank (
    .clk       (clk),
    .rst       (rst),
    .we        (reg_we),
    .waddr     (addr_q),
    .wdata     (bus.rx_byte),
    .raddr     (raddr),
    .rdata     (rdata),
    .regs_flat (regs_flat)
  );

endmodule

// File: tb/tb_spi_frame_decoder.sv
// Directed self-checking bench for spi_frame_decoder with REG_COUNT = 16.
// Frames are driven byte by byte; expected values are hand-computed constants.
module tb_spi_frame_decoder;
  import spi_frame_pkg::*;

  localparam int REG_COUNT = 16;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [REG_COUNT*8-1:0] regs_flat;
  logic                   wr_strobe;
  logic [ADDR_W-1:0]      wr_addr;
  logic                   frame_active;
  logic                   addr_err;

  int checks   = 0;
  int failures = 0;

  spi_frame_decoder_if bus ();

  spi_frame_decoder #(
    .REG_COUNT   (REG_COUNT),
    .STATUS_BYTE (8'hA5),
    .RESET_VALUE (8'h00)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .regs_flat    (regs_flat),
    .wr_strobe    (wr_strobe),
    .wr_addr      (wr_addr),
    .frame_active (frame_active),
    .addr_err     (addr_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [7:0] regAt(input int i);
    return regs_flat[8*i +: 8];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle rx_valid strobe; returns just after the edge that consumed it.
  task automatic applyStimulus(input logic [7:0] b);
    bus.rx_byte  = b;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic startFrame();
    logic seen;
    seen   = 1'b0;
    bus.cs = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      seen = bus.tx_valid;
    end
    checkOutput("status_tx_valid", 32'(seen), 1);
    checkOutput("status_tx_byte", 32'(bus.tx_byte), 32'hA5);
    checkOutput("frame_active_start", 32'(frame_active), 1);
    tick();
    checkOutput("status_pulse_width", 32'(bus.tx_valid), 0);
  endtask

  task automatic endFrame();
    bus.cs = 1'b1;
    repeat (5) tick();
    checkOutput("frame_active_end", 32'(frame_active), 0);
  endtask

  task automatic checkAllRegsZero(input string tag);
    logic any_set;
    any_set = 1'b0;
    for (int i = 0; i < REG_COUNT; i++) begin
      if (regAt(i) != 8'h00) any_set = 1'b1;
    end
    checkOutput(tag, 32'(any_set), 0);
  endtask

  initial begin
    int tx_seen;
    bus.cs       = 1'b1;
    bus.rx_byte  = 8'h00;
    bus.rx_valid = 1'b0;
    rst          = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (4) tick();

    // Reset state and an empty frame
    checkOutput("rst_tx_valid", 32'(bus.tx_valid), 0);
    checkOutput("rst_tx_byte", 32'(bus.tx_byte), 0);
    checkOutput("rst_wr_strobe", 32'(wr_strobe), 0);
    checkOutput("rst_frame_active", 32'(frame_active), 0);
    checkOutput("rst_addr_err", 32'(addr_err), 0);
    checkAllRegsZero("rst_regs");
    startFrame();
    checkAllRegsZero("empty_frame_regs");
    endFrame();

    // Write burst starting at address 2
    startFrame();
    applyStimulus(8'h82);
    checkOutput("wr_cmd_no_strobe", 32'(wr_strobe), 0);
    checkOutput("wr_cmd_no_tx", 32'(bus.tx_valid), 0);
    tick();
    applyStimulus(8'h11);
    checkOutput("wr0_strobe", 32'(wr_strobe), 1);
    checkOutput("wr0_addr", 32'(wr_addr), 2);
    checkOutput("wr0_reg2", 32'(regAt(2)), 32'h11);
    checkOutput("wr0_no_tx", 32'(bus.tx_valid), 0);
    tick();
    checkOutput("wr0_strobe_width", 32'(wr_strobe), 0);
    applyStimulus(8'h22);
    checkOutput("wr1_strobe", 32'(wr_strobe), 1);
    checkOutput("wr1_addr", 32'(wr_addr), 3);
    tick();
    applyStimulus(8'h33);
    checkOutput("wr2_strobe", 32'(wr_strobe), 1);
    checkOutput("wr2_addr", 32'(wr_addr), 4);
    checkOutput("wr2_no_tx", 32'(bus.tx_valid), 0);
    tick();
    checkOutput("wr_reg3", 32'(regAt(3)), 32'h22);
    checkOutput("wr_reg4", 32'(regAt(4)), 32'h33);
    checkOutput("wr_reg1_untouched", 32'(regAt(1)), 0);
    endFrame();

    // Read burst from address 3: replies 22, 33, 00
    startFrame();
    applyStimulus(8'h03);
    checkOutput("rd0_tx_valid", 32'(bus.tx_valid), 1);
    checkOutput("rd0_tx_byte", 32'(bus.tx_byte), 32'h22);
    tick();
    checkOutput("rd0_pulse_width", 32'(bus.tx_valid), 0);
    checkOutput("rd0_tx_hold", 32'(bus.tx_byte), 32'h22);
    applyStimulus(8'hFF);
    checkOutput("rd1_tx_valid", 32'(bus.tx_valid), 1);
    checkOutput("rd1_tx_byte", 32'(bus.tx_byte), 32'h33);
    tick();
    applyStimulus(8'hFF);
    checkOutput("rd2_tx_valid", 32'(bus.tx_valid), 1);
    checkOutput("rd2_tx_byte", 32'(bus.tx_byte), 32'h00);
    checkOutput("rd_no_err", 32'(addr_err), 0);
    checkOutput("rd_no_strobe", 32'(wr_strobe), 0);
    tick();
    endFrame();

    // Write at the top of the bank runs past REG_COUNT
    startFrame();
    applyStimulus(8'h8F);
    tick();
    applyStimulus(8'hAA);
    checkOutput("top_strobe", 32'(wr_strobe), 1);
    checkOutput("top_addr", 32'(wr_addr), 15);
    checkOutput("top_reg15", 32'(regAt(15)), 32'hAA);
    checkOutput("top_err_clear", 32'(addr_err), 0);
    tick();
    applyStimulus(8'hBB);
    checkOutput("oor_no_strobe", 32'(wr_strobe), 0);
    checkOutput("oor_err_set", 32'(addr_err), 1);
    checkOutput("oor_reg0", 32'(regAt(0)), 0);
    tick();
    endFrame();
    checkOutput("err_sticky", 32'(addr_err), 1);

    // cs rises on the same cycle as a data byte: byte still commits
    startFrame();
    applyStimulus(8'h85);
    tick();
    bus.cs = 1'b1;
    applyStimulus(8'h5C);
    checkOutput("csr_strobe", 32'(wr_strobe), 1);
    checkOutput("csr_addr", 32'(wr_addr), 5);
    checkOutput("csr_reg5", 32'(regAt(5)), 32'h5C);
    repeat (5) tick();
    checkOutput("csr_idle", 32'(frame_active), 0);
    applyStimulus(8'h77);
    checkOutput("idle_rx_no_strobe", 32'(wr_strobe), 0);
    checkOutput("idle_rx_no_tx", 32'(bus.tx_valid), 0);
    tick();
    checkOutput("idle_rx_reg6", 32'(regAt(6)), 0);
    checkOutput("idle_rx_reg5", 32'(regAt(5)), 32'h5C);

    // Reset in the middle of a read frame
    startFrame();
    applyStimulus(8'h03);
    checkOutput("mid_rd_tx_byte", 32'(bus.tx_byte), 32'h22);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("mrst_tx_valid", 32'(bus.tx_valid), 0);
    checkOutput("mrst_tx_byte", 32'(bus.tx_byte), 0);
    checkOutput("mrst_frame_active", 32'(frame_active), 0);
    checkOutput("mrst_addr_err", 32'(addr_err), 0);
    checkOutput("mrst_wr_addr", 32'(wr_addr), 0);
    checkAllRegsZero("mrst_regs");
    tx_seen = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(8'hFF);
      if (bus.tx_valid) tx_seen++;
      tick();
      if (bus.tx_valid) tx_seen++;
    end
    checkOutput("mrst_frame_ignored", 32'(tx_seen), 0);
    checkOutput("mrst_still_idle", 32'(frame_active), 0);
    endFrame();
    startFrame();
    endFrame();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
